read_data_framer: RTL and testbench



---
 rtl/read_data_framer.sv | 168 ++++++++++++++++
 tb/tb_read_data_framer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/read_data_framer.sv
// read_data_framer: folds ADC samples, peak-detects per bit window, slices bits
// against a mean_def-derived threshold and assembles start-bit framed words.
//
// Ports:
//   clk, nrst          clock, synchronous active-low reset
//   program_mode[1:0]  mode select, block runs only at 2'b11
//                      ("program" is a reserved word in SystemVerilog)
//   readDataIn         receive enable
//   ADC[ADC_W-1:0]     raw unsigned sample, one per clock
//   mean_def           reference level, sampled on each window's last cycle
//   din, bit_strobe    sliced bit and its one-cycle update pulse
//   data, data_valid   last completed frame and its one-cycle update pulse
//   busy               frame reception in progress
//   parity_err         even-parity check result (READ_DATA_PARITY_EN only)
//
// Optional: define READ_DATA_PARITY_EN to add a trailing even-parity window.
module read_data_framer #(
  parameter int ADC_W      = 12,
  parameter int BIT_CYCLES = 40000,
  parameter int THRESH_DIV = 15,
  parameter int FRAME_BITS = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [1:0]            program_mode,
  input  logic                  readDataIn,
  input  logic [ADC_W-1:0]      ADC,
  input  logic [ADC_W-1:0]      mean_def,
  output logic                  din,
  output logic                  bit_strobe,
  output logic [FRAME_BITS-1:0] data,
  output logic                  data_valid,
`ifdef READ_DATA_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  busy
);

  localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = $clog2(FRAME_BITS + 1);
  localparam int PW = ADC_W - 1;

  localparam logic [CW-1:0] CNT_TOP  = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1
`ifdef READ_DATA_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t state, state_nx;

  logic                  run;
  logic                  eval;
  logic                  b;
  logic [ADC_W-1:0]      thr;
  logic [PW-1:0]         folded;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [PW-1:0]         peak, peak_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [FRAME_BITS-1:0] shreg, shreg_nx;
  logic [FRAME_BITS-1:0] data_nx;
  logic                  din_nx;
  logic                  strobe_nx;
  logic                  dv_nx;
`ifdef READ_DATA_PARITY_EN
  logic                  perr_nx;
`endif

  assign run = nrst & (program_mode == 2'b11) & readDataIn;

  // Above mid-scale FULL-ADC is the bitwise inverse; its MSB is always 0.
  assign folded = ADC[ADC_W-1] ? ~ADC[PW-1:0] : ADC[PW-1:0];

  assign thr  = mean_def - mean_def / ADC_W'(THRESH_DIV);
  assign eval = (cnt == '0);
  // Peak excludes the evaluation cycle's own sample.
  assign b    = ({1'b0, peak} < thr);
  assign busy = (state != IDLE);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt - CW'(1);
    peak_nx   = (folded > peak) ? folded : peak;
    idx_nx    = idx;
    shreg_nx  = shreg;
    data_nx   = data;
    din_nx    = din;
    strobe_nx = 1'b0;
    dv_nx     = 1'b0;
`ifdef READ_DATA_PARITY_EN
    perr_nx   = parity_err;
`endif
    if (eval) begin
      cnt_nx    = CNT_TOP;
      peak_nx   = '0;
      din_nx    = b;
      strobe_nx = 1'b1;
      unique case (state)
        IDLE: begin
          if (b) begin
            state_nx = DATA;
            idx_nx   = '0;
            shreg_nx = '0;
          end
        end
        DATA: begin
          // Shift in at LSB so the first data bit ends up in the MSB.
          shreg_nx = FRAME_BITS'({shreg, b});
          idx_nx   = idx + IW'(1);
          if (idx == IDX_LAST) begin
`ifdef READ_DATA_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = IDLE;
            data_nx  = shreg_nx;
            dv_nx    = 1'b1;
`endif
          end
        end
`ifdef READ_DATA_PARITY_EN
        PARITY: begin
          state_nx = IDLE;
          data_nx  = shreg;
          dv_nx    = 1'b1;
          perr_nx  = ^shreg ^ b;
        end
`endif
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      state      <= IDLE;
      cnt        <= CNT_TOP;
      peak       <= '0;
      idx        <= '0;
      shreg      <= '0;
      din        <= 1'b0;
      bit_strobe <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
`ifdef READ_DATA_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      peak       <= peak_nx;
      idx        <= idx_nx;
      shreg      <= shreg_nx;
      din        <= din_nx;
      bit_strobe <= strobe_nx;
      data       <= data_nx;
      data_valid <= dv_nx;
`ifdef READ_DATA_PARITY_EN
      parity_err <= perr_nx;
`endif
    end
  end

endmodule

// File: tb/tb_read_data_framer.sv
// tb_read_data_framer: directed bench for read_data_framer.
// Short windows (16 cycles), threshold 1912 from mean_def=2048.
module tb_read_data_framer;

  localparam int BC = 16;
  localparam int FB = 8;
`ifdef READ_DATA_PARITY_EN
  localparam int FRAME_WIN = FB + 2;
`else
  localparam int FRAME_WIN = FB + 1;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic [1:0]  program_mode;
  logic        readDataIn;
  logic [11:0] adc;
  logic [11:0] mean_def;
  logic        din;
  logic        bit_strobe;
  logic [7:0]  data;
  logic        data_valid;
  logic        busy;
`ifdef READ_DATA_PARITY_EN
  logic        parity_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_cyc = 0;
  int t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  read_data_framer #(
    .ADC_W(12),
    .BIT_CYCLES(BC),
    .THRESH_DIV(15),
    .FRAME_BITS(FB)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .program_mode(program_mode),
    .readDataIn(readDataIn),
    .ADC(adc),
    .mean_def(mean_def),
    .din(din),
    .bit_strobe(bit_strobe),
    .data(data),
    .data_valid(data_valid),
`ifdef READ_DATA_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic window(input logic [11:0] base, input logic [11:0] spike,
                        input int at, input logic e_din,
                        input logic e_dv, input logic e_busy);
    for (int i = 0; i < BC; i++) begin
      adc = (i == at) ? spike : base;
      tick();
      if (i == BC - 2) begin
        chk("strobe_early", bit_strobe, 1'b0);
        chk("dv_early", data_valid, 1'b0);
      end
    end
    chk("strobe", bit_strobe, 1'b1);
    chk("din", din, e_din);
    chk("dv", data_valid, e_dv);
    chk("busy", busy, e_busy);
    if (data_valid) dv_cyc = cyc;
  endtask

  task automatic bitw(input logic b, input logic e_dv, input logic e_busy);
    window(b ? 12'h100 : 12'h800, 12'h000, -1, b, e_dv, e_busy);
  endtask

  task automatic frame(input logic [7:0] d, input logic par,
                       input logic e_perr);
    bitw(1'b1, 1'b0, 1'b1);
    for (int i = FB - 1; i >= 0; i--) begin
`ifdef READ_DATA_PARITY_EN
      bitw(d[i], 1'b0, 1'b1);
`else
      bitw(d[i], i == 0, i != 0);
`endif
    end
`ifdef READ_DATA_PARITY_EN
    bitw(par, 1'b1, 1'b0);
    chk("parity_err", parity_err, e_perr);
`else
    chk("par_unused", {31'd0, par ^ e_perr}, {31'd0, par ^ e_perr});
`endif
    chk("data", data, d);
  endtask

  task automatic abort_run();
    readDataIn = 1'b0;
    tick();
    chk("ab_busy", busy, 1'b0);
    chk("ab_dv", data_valid, 1'b0);
    chk("ab_data", data, 8'h00);
    chk("ab_din", din, 1'b0);
    chk("ab_strobe", bit_strobe, 1'b0);
    readDataIn = 1'b1;
  endtask

  initial begin
    nrst         = 1'b0;
    program_mode = 2'b11;
    readDataIn   = 1'b1;
    adc          = 12'h800;
    mean_def     = 12'd2048;
    repeat (5) tick();
    chk("rst_din", din, 1'b0);
    chk("rst_strobe", bit_strobe, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
`ifdef READ_DATA_PARITY_EN
    chk("rst_perr", parity_err, 1'b0);
`endif

    // run rises here; first strobe lands exactly BC edges later
    nrst = 1'b1;
    window(12'h800, 12'h000, -1, 1'b0, 1'b0, 1'b0);

    // peak 256 slices to 1 and is taken as a start bit
    bitw(1'b1, 1'b0, 1'b1);
    abort_run();

    // peak exactly at threshold slices to 0
    window(12'h778, 12'h000, -1, 1'b0, 1'b0, 1'b0);
    window(12'h100, 12'h778, 5, 1'b0, 1'b0, 1'b0);

    // frame then back-to-back frame
    frame(8'hA5, 1'b1, 1'b1);
    t0 = dv_cyc;
    frame(8'h3C, 1'b0, 1'b0);
    chk("b2b_gap", dv_cyc - t0, FRAME_WIN * BC);

    // abort after 4 data bits, then a full frame
    bitw(1'b1, 1'b0, 1'b1);
    repeat (4) bitw(1'b1, 1'b0, 1'b1);
    abort_run();
    frame(8'hFF, 1'b0, 1'b0);
    frame(8'hA5, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
